// File: rtl/adxl345_iic_scheduler.sv
// rtl/adxl345_iic_scheduler.sv - shares one I2C master between a config port and an ADXL345 burst-read stream
module adxl345_iic_scheduler #(
    parameter logic [6:0] DEVICE_ADDR = 7'h53,
    parameter logic [7:0] DATA_PTR    = 8'h32,
    parameter int         BURST_LEN   = 6,
    parameter int         PERIOD      = 100000,
    parameter int         TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_rw,
    input  logic [7:0]  cfg_ptr,
    input  logic [7:0]  cfg_wdata,
    output logic [7:0]  cfg_rdata,
    output logic        cfg_done,
    output logic        cfg_err,
    input  logic        irq,
    input  logic        irq_en,
    input  logic        tmr_en,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic [15:0] drop_cnt,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_addr,
    output logic        cmd_rw,
    output logic [7:0]  cmd_ptr,
    output logic [3:0]  cmd_len,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    input  logic        cmp_done,
    input  logic        cmp_err
);

    localparam int         PW   = $clog2(PERIOD);
    localparam int         TW   = $clog2(TIMEOUT + 1);
    localparam logic [3:0] BLEN = 4'(BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_WAIT, S_DONE} state_t;

    state_t        state, state_n;
    logic          irq_s1, irq_s2, irq_d;
    logic [PW-1:0] tmr_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    byte_cnt;
    logic          stream_pend;
    logic          is_cfg, cfg_rw_q, err_q;
    logic [7:0]    cfg_ptr_q, cfg_wdata_q;
    logic          irq_rise, tmr_wrap, trig, take_cfg, take_stream, tmo_hit;

    assign irq_rise    = irq_s2 & ~irq_d;
    assign tmr_wrap    = tmr_en && (tmr_cnt == PW'(PERIOD - 1));
    assign trig        = (irq_rise & irq_en) | tmr_wrap;
    assign take_cfg    = (state == S_IDLE) && cfg_valid;
    assign take_stream = (state == S_IDLE) && !cfg_valid && stream_pend;
    // DONE is entered exactly TIMEOUT cycles after CMD entry
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cfg_ready = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 7'd0;
        cmd_rw    = 1'b0;
        cmd_ptr   = 8'd0;
        cmd_len   = 4'd0;
        wr_valid  = 1'b0;
        wr_data   = 8'd0;
        case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    cfg_ready = 1'b1;
                    state_n   = S_CMD;
                end else if (stream_pend) begin
                    state_n = S_CMD;
                end
            end
            S_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = DEVICE_ADDR;
                cmd_rw    = is_cfg ? cfg_rw_q : 1'b1;
                cmd_ptr   = is_cfg ? cfg_ptr_q : DATA_PTR;
                cmd_len   = is_cfg ? 4'd1 : BLEN;
                if (tmo_hit) begin
                    state_n = S_DONE;
                end else if (cmd_ready) begin
                    state_n = (is_cfg && !cfg_rw_q) ? S_WDATA : S_WAIT;
                end
            end
            S_WDATA: begin
                wr_valid = 1'b1;
                wr_data  = cfg_wdata_q;
                if (tmo_hit) begin
                    state_n = S_DONE;
                end else if (wr_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cmp_done || tmo_hit) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1      <= 1'b0;
            irq_s2      <= 1'b0;
            irq_d       <= 1'b0;
            tmr_cnt     <= '0;
            tmo_cnt     <= '0;
            byte_cnt    <= 4'd0;
            stream_pend <= 1'b0;
            drop_cnt    <= 16'd0;
            is_cfg      <= 1'b0;
            cfg_rw_q    <= 1'b0;
            cfg_ptr_q   <= 8'd0;
            cfg_wdata_q <= 8'd0;
            err_q       <= 1'b0;
            cfg_rdata   <= 8'd0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            m_tdata     <= 8'd0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
        end else begin
            irq_s1 <= irq;
            irq_s2 <= irq_s1;
            irq_d  <= irq_s2;

            if (!tmr_en || tmr_wrap) begin
                tmr_cnt <= '0;
            end else begin
                tmr_cnt <= tmr_cnt + PW'(1);
            end

            // A trigger coinciding with consumption re-arms without counting as a drop
            if (take_stream) begin
                stream_pend <= trig;
            end else if (trig) begin
                stream_pend <= 1'b1;
                if (stream_pend && drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end

            if (take_cfg) begin
                is_cfg      <= 1'b1;
                cfg_rw_q    <= cfg_rw;
                cfg_ptr_q   <= cfg_ptr;
                cfg_wdata_q <= cfg_wdata;
            end else if (take_stream) begin
                is_cfg <= 1'b0;
            end

            if (state == S_IDLE || state == S_DONE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (state != S_DONE && state_n == S_DONE) begin
                err_q <= (state == S_WAIT && cmp_done) ? cmp_err : 1'b1;
            end

            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            if (state == S_IDLE) begin
                byte_cnt <= 4'd0;
            end else if (state == S_WAIT && rd_valid) begin
                if (is_cfg) begin
                    cfg_rdata <= rd_data;
                end else if (byte_cnt != BLEN) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= rd_data;
                    m_tlast  <= (byte_cnt == BLEN - 4'd1);
                    byte_cnt <= byte_cnt + 4'd1;
                end
            end

            cfg_done <= (state == S_DONE) && is_cfg;
            cfg_err  <= (state == S_DONE) && is_cfg && err_q;
        end
    end

endmodule

// File: tb/tb_adxl345_iic_scheduler.sv
// tb/tb_adxl345_iic_scheduler.sv - self-checking bench for adxl345_iic_scheduler
module tb_adxl345_iic_scheduler;

    localparam int TMO = 100;
    localparam int PER = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready, cfg_rw, cfg_done, cfg_err;
    logic [7:0]  cfg_ptr, cfg_wdata, cfg_rdata;
    logic        irq, irq_en, tmr_en;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast;
    logic [15:0] drop_cnt;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_ptr;
    logic [3:0]  cmd_len;
    logic [7:0]  wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, cmp_done, cmp_err;

    always #5 clk = ~clk;

    adxl345_iic_scheduler #(
        .DEVICE_ADDR(7'h53), .DATA_PTR(8'h32), .BURST_LEN(6), .PERIOD(PER), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rw(cfg_rw), .cfg_ptr(cfg_ptr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .irq(irq), .irq_en(irq_en), .tmr_en(tmr_en),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .drop_cnt(drop_cnt),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
        .cmd_ptr(cmd_ptr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .cmp_done(cmp_done), .cmp_err(cmp_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic       rw;
        logic [7:0] ptr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         gap;
        logic       cmp_err;
        logic       no_cmp;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } cfg_vec_t;

    cfg_vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream scoreboard: every forwarded byte must match the head of the queue
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_tvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stream_byte: got %0h expected none", {m_tlast, m_tdata});
            end else begin
                chk("stream_byte", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cmd(input string name);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, cmd_valid, 1);
    endtask

    task automatic do_cfg(input cfg_vec_t v);
        int n = 0;
        int e;
        cfg_valid = 1'b1;
        cfg_rw    = v.rw;
        cfg_ptr   = v.ptr;
        cfg_wdata = v.wdata;
        #1;
        while (cfg_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("cfg_ready", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        e = cyc;
        chk("cfg_cmd_latency", cmd_valid, 1);
        chk("cfg_cmd_fields", {cmd_addr, cmd_rw, cmd_ptr, cmd_len}, {7'h53, v.rw, v.ptr, 4'd1});
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("cmd_valid_drop", cmd_valid, 0);
        if (!v.rw) begin
            chk("wr_valid_data", {wr_valid, wr_data}, {1'b1, v.wdata});
            wr_ready = 1'b1;
            @(negedge clk);
            wr_ready = 1'b0;
        end else begin
            rd_data  = v.rdata;
            rd_valid = 1'b1;
            @(negedge clk);
            rd_valid = 1'b0;
        end
        if (!v.no_cmp) begin
            repeat (v.gap) @(negedge clk);
            cmp_done = 1'b1;
            cmp_err  = v.cmp_err;
            @(negedge clk);
            cmp_done = 1'b0;
            cmp_err  = 1'b0;
            chk("cfg_done_early", cfg_done, 0);
            @(negedge clk);
        end else begin
            n = 0;
            while (cfg_done !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            // DONE at TIMEOUT cycles after command entry, CFG_DONE registered one later
            chk("timeout_latency", cyc - e, TMO + 1);
        end
        chk("cfg_done", cfg_done, 1);
        chk("cfg_err", cfg_err, v.exp_err);
        chk("cfg_rdata", cfg_rdata, v.exp_rdata);
        @(negedge clk);
        chk("cfg_done_pulse", cfg_done, 0);
    endtask

    task automatic irq_pulse();
        irq = 1'b1;
        repeat (4) @(negedge clk);
        irq = 1'b0;
    endtask

    task automatic do_burst(input int nbytes, input logic err, input logic toggle, input logic [7:0] base);
        wait_cmd("burst_cmd_seen");
        chk("burst_cmd_fields", {cmd_addr, cmd_rw, cmd_ptr, cmd_len}, {7'h53, 1'b1, 8'h32, 4'd6});
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            if (i < 6) exp_q.push_back({(i == 5), base + 8'(i)});
            rd_data  = base + 8'(i);
            rd_valid = 1'b1;
            if (toggle) irq = (i == 0 || i == 3);
            @(negedge clk);
        end
        rd_valid = 1'b0;
        if (toggle) irq = 1'b0;
        cmp_done = 1'b1;
        cmp_err  = err;
        @(negedge clk);
        cmp_done = 1'b0;
        cmp_err  = 1'b0;
        repeat (3) @(negedge clk);
        chk("burst_drain", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{rw: 1'b0, ptr: 8'h2D, wdata: 8'h08, rdata: 8'h00, gap: 50, cmp_err: 1'b0, no_cmp: 1'b0, exp_err: 1'b0, exp_rdata: 8'h00};
        vecs[1] = '{rw: 1'b1, ptr: 8'h00, wdata: 8'h00, rdata: 8'hE5, gap: 5,  cmp_err: 1'b0, no_cmp: 1'b0, exp_err: 1'b0, exp_rdata: 8'hE5};
        vecs[2] = '{rw: 1'b0, ptr: 8'h31, wdata: 8'h0B, rdata: 8'h00, gap: 3,  cmp_err: 1'b1, no_cmp: 1'b0, exp_err: 1'b1, exp_rdata: 8'hE5};
        vecs[3] = '{rw: 1'b0, ptr: 8'h2C, wdata: 8'h0A, rdata: 8'h00, gap: 0,  cmp_err: 1'b0, no_cmp: 1'b1, exp_err: 1'b1, exp_rdata: 8'hE5};
        vecs[4] = '{rw: 1'b1, ptr: 8'h2C, wdata: 8'h00, rdata: 8'h0A, gap: 2,  cmp_err: 1'b0, no_cmp: 1'b0, exp_err: 1'b0, exp_rdata: 8'h0A};

        rst_n = 1'b0;
        cfg_valid = 0; cfg_rw = 0; cfg_ptr = 0; cfg_wdata = 0;
        irq = 0; irq_en = 1; tmr_en = 0;
        cmd_ready = 0; wr_ready = 0; rd_data = 0; rd_valid = 0; cmp_done = 0; cmp_err = 0;
        repeat (3) @(negedge clk);
        chk("reset_strobes", {cfg_ready, cfg_done, cfg_err, m_tvalid, m_tlast, cmd_valid, wr_valid}, 0);
        chk("reset_data", {cfg_rdata, m_tdata, drop_cnt}, 0);
        chk("reset_cmd_fields", {cmd_addr, cmd_rw, cmd_ptr, cmd_len}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            do_cfg(vecs[k]);
            repeat (2) @(negedge clk);
        end

        irq_pulse();
        do_burst(6, 1'b0, 1'b0, 8'h01);
        irq_pulse();
        do_burst(8, 1'b0, 1'b0, 8'h11);
        irq_pulse();
        do_burst(3, 1'b1, 1'b0, 8'h21);
        chk("drop_none_yet", drop_cnt, 0);

        irq = 1'b1;
        do_cfg('{rw: 1'b1, ptr: 8'h00, wdata: 8'h00, rdata: 8'hE5, gap: 2, cmp_err: 1'b0, no_cmp: 1'b0, exp_err: 1'b0, exp_rdata: 8'hE5});
        irq = 1'b0;
        chk("contention_drop0", drop_cnt, 0);
        do_burst(6, 1'b0, 1'b1, 8'h31);
        chk("contention_drop1", drop_cnt, 1);
        do_burst(6, 1'b0, 1'b0, 8'h41);
        chk("pending_burst_drop1", drop_cnt, 1);

        tmr_en = 1'b1;
        repeat (PER + 1) @(negedge clk);
        tmr_en = 1'b0;
        do_burst(6, 1'b0, 1'b0, 8'h51);

        irq_pulse();
        wait_cmd("reset_burst_cmd_seen");
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 8'h61 + 8'(i)});
            rd_data  = 8'h61 + 8'(i);
            rd_valid = 1'b1;
            @(negedge clk);
        end
        rd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_bytes", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("midburst_reset_strobes", {cfg_done, cfg_err, m_tvalid, m_tlast, cmd_valid, wr_valid}, 0);
        chk("midburst_reset_data", {cfg_rdata, m_tdata, drop_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", cmd_valid, 0);
        irq_pulse();
        do_burst(6, 1'b0, 1'b0, 8'h71);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
